rv_result_dump: RTL and testbench
=================================

Name: rv_result_dump

Overview:
- Read-side companion to the RISC-V matrix-multiply core.
- After the core raises done, the block:
  - latches the core's clock and instruction counters;
  - reads the result-matrix region of data memory through a second read port;
  - streams everything out as a byte-wide valid/ready frame for a UART/JTAG bridge.
- It sits beside the core and is the only consumer of the result region after execution.

Parameters:
- M, 9, rows of matrix A.
- N, 9, columns of A / rows of B.
- N2, 9, columns of B.
- REG_WIDTH, 32, data-memory word width in bits; must be a multiple of 8.
- BASE, M*N+N*N2, word index of the first result word (C[0][0]).
- HDR, 8'hA5, frame start byte.
- TRL, 8'h5A, frame end byte.

Ports:
- CLOCK_50  in  1  system clock, all logic on posedge.
- rstn  in  1  synchronous active-low reset.
- done  in  1  core completion flag (level).
- clock_count  in  32  core cycle counter.
- instr_count  in  32  core retired-instruction counter.
- mem_rd_en  out  1  data-memory read strobe.
- mem_index  out  32  data-memory word index.
- mem_data  in  REG_WIDTH  read data, valid exactly 1 cycle after the mem_rd_en edge.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts.
- dump_busy  out  1  high from trigger until the trailer is accepted.
- dump_done  out  1  high after a completed frame, until rearm.

Behaviour:
- Reset values (rstn low at posedge): state=IDLE, tx_valid=0, tx_data=0, mem_rd_en=0, mem_index=0, dump_busy=0, dump_done=0, latched counters=0.
- Reset mid-frame aborts the frame; no partial trailer is sent.
- Trigger:
  - Trigger on a done rising edge: registered done_q=0 and done=1.
  - On that edge, latch clock_count and instr_count, then enter HDR.
  - A level-high done coming out of reset does count as a rising edge, because done_q resets to 0.
- Frame byte order, total 1+8+4*BYTES*M*N2... precisely 1 + 8 + (REG_WIDTH/8)*M*N2 + 1 bytes:
  1. HDR byte.
  2. Latched clock_count, 4 bytes LSB first.
  3. Latched instr_count, 4 bytes LSB first.
  4. Words BASE .. BASE+M*N2-1 in ascending index order, each REG_WIDTH/8 bytes LSB first.
  5. TRL byte.
- States:
  - IDLE: on trigger -> HDR.
  - HDR: present HDR -> CNT.
  - CNT: 8-byte counter shift -> RD_REQ.
  - RD_REQ: mem_rd_en=1 for exactly one cycle with mem_index=BASE+word_idx -> RD_WAIT.
  - RD_WAIT: capture mem_data into the shift register next cycle -> SEND.
  - SEND: shift out REG_WIDTH/8 bytes. After the last byte, if word_idx==M*N2-1 -> TRL; else word_idx+1 -> RD_REQ.
  - TRL: present TRL; on acceptance -> DONE.
  - DONE: dump_done=1; when done==0 -> IDLE (rearm).
- Handshake:
  - A byte transfers on a posedge with tx_valid&&tx_ready.
  - Once tx_valid is asserted, tx_data must stay stable and tx_valid must stay high until the transfer. No retraction.
  - tx_ready may be held low indefinitely; the block waits with no loss or duplication.
  - tx_valid is low in IDLE, RD_REQ, RD_WAIT and DONE.
  - With tx_ready tied high, each byte is presented for exactly one cycle. Per-word overhead is 2 bubble cycles (RD_REQ and RD_WAIT).
- Counters:
  - byte_idx counts 0..REG_WIDTH/8-1 and wraps.
  - word_idx counts 0..M*N2-1.
  - mem_index arithmetic is 32-bit unsigned, with no wrap for legal parameters.
- done activity during a frame:
  - done falling mid-frame does not abort.
  - done rising again mid-frame is ignored, and the counters are not relatched.
- dump_busy equals state not in {IDLE, DONE}.
- The block never writes memory. mem_rd_en is only asserted in RD_REQ.

Test Plan:
- Basic frame (M=N=N2=2, BASE=8, REG_WIDTH=32):
  - Stimulus: mem[8..11]=32'h11223344, 32'hAABBCCDD, 32'h00000001, 32'hFFFFFFFF; clock_count=32'h00000064; instr_count=32'h0000002A; done rises; tx_ready=1.
  - Required: exactly 26 bytes: A5, 64 00 00 00, 2A 00 00 00, 44 33 22 11, DD CC BB AA, 01 00 00 00, FF FF FF FF, 5A.
  - Then dump_done=1 and dump_busy=0.
- Backpressure:
  - Stimulus: same setup, tx_ready toggled in a 1-high/3-low pattern.
  - Required: the identical 26-byte sequence; tx_data stable while tx_valid && !tx_ready; no duplicate bytes.
- Memory timing:
  - Stimulus: monitor mem_rd_en and mem_index during a frame.
  - Required: exactly 4 single-cycle pulses at indices 8, 9, 10, 11, in order; each followed by the first word byte at least 2 cycles later.
- Counter latch:
  - Stimulus: clock_count keeps incrementing after done rises.
  - Required: counter bytes equal the value sampled at the trigger edge.
- Reset mid-operation:
  - Stimulus: rstn=0 for 1 cycle at byte 12.
  - Required: next cycle tx_valid=0, dump_busy=0, dump_done=0; no further bytes. A fresh done rising edge produces a full 26-byte frame.
- Rearm:
  - Stimulus: after DONE, done=0 for 1 cycle, then done=1.
  - Required: a second complete frame with newly latched counters. done held high with no rising edge produces no second frame.

Source files
------------

// File: rtl/rv_result_dump.sv
// Post-run result dumper: latches the core counters, reads the result matrix through a
// second memory read port and streams it out as a byte-wide valid/ready frame.
module rv_result_dump #(
   parameter int         M         = 9,
   parameter int         N         = 9,
   parameter int         N2        = 9,
   parameter int         REG_WIDTH = 32,
   parameter int         BASE      = M*N + N*N2,
   parameter logic [7:0] HDR       = 8'hA5,
   parameter logic [7:0] TRL       = 8'h5A
) (
   input  logic                 CLOCK_50,
   input  logic                 rstn,
   input  logic                 done,
   input  logic [31:0]          clock_count,
   input  logic [31:0]          instr_count,
   output logic                 mem_rd_en,
   output logic [31:0]          mem_index,
   input  logic [REG_WIDTH-1:0] mem_data,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 dump_busy,
   output logic                 dump_done
);

   localparam int BYTES = REG_WIDTH / 8;
   localparam int WORDS = M * N2;
   localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR, ST_CNT, ST_RD_REQ, ST_RD_WAIT, ST_SEND, ST_TRL, ST_DONE
   } state_t;

   state_t               state;
   logic                 done_q;
   logic [63:0]          cnt_sr;
   logic [2:0]           cnt_idx;
   logic [REG_WIDTH-1:0] word_sr;
   logic [BI_W-1:0]      byte_idx;
   logic [31:0]          word_idx;
   logic                 accept;

   assign accept    = tx_valid && tx_ready;
   assign dump_busy = (state != ST_IDLE) && (state != ST_DONE);

   always_ff @(posedge CLOCK_50) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         done_q    <= 1'b0;
         cnt_sr    <= '0;
         cnt_idx   <= '0;
         word_sr   <= '0;
         byte_idx  <= '0;
         word_idx  <= '0;
         mem_rd_en <= 1'b0;
         mem_index <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
         dump_done <= 1'b0;
      end else begin
         done_q <= done;
         case (state)
            ST_IDLE: begin
               if (done && !done_q) begin
                  // clock_count in the low half so it leaves the shifter first
                  cnt_sr   <= {instr_count, clock_count};
                  tx_data  <= HDR;
                  tx_valid <= 1'b1;
                  state    <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (accept) begin
                  tx_data <= cnt_sr[7:0];
                  cnt_sr  <= cnt_sr >> 8;
                  cnt_idx <= '0;
                  state   <= ST_CNT;
               end
            end
            ST_CNT: begin
               if (accept) begin
                  if (cnt_idx == 3'd7) begin
                     tx_valid  <= 1'b0;
                     word_idx  <= '0;
                     mem_rd_en <= 1'b1;
                     mem_index <= 32'(BASE);
                     state     <= ST_RD_REQ;
                  end else begin
                     tx_data <= cnt_sr[7:0];
                     cnt_sr  <= cnt_sr >> 8;
                     cnt_idx <= cnt_idx + 3'd1;
                  end
               end
            end
            ST_RD_REQ: begin
               mem_rd_en <= 1'b0;
               state     <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               tx_data  <= mem_data[7:0];
               word_sr  <= mem_data >> 8;
               tx_valid <= 1'b1;
               byte_idx <= '0;
               state    <= ST_SEND;
            end
            ST_SEND: begin
               if (accept) begin
                  if (byte_idx == BI_W'(BYTES-1)) begin
                     byte_idx <= '0;
                     if (word_idx == 32'(WORDS-1)) begin
                        tx_data <= TRL;
                        state   <= ST_TRL;
                     end else begin
                        word_idx  <= word_idx + 32'd1;
                        mem_index <= 32'(BASE) + word_idx + 32'd1;
                        mem_rd_en <= 1'b1;
                        tx_valid  <= 1'b0;
                        state     <= ST_RD_REQ;
                     end
                  end else begin
                     tx_data  <= word_sr[7:0];
                     word_sr  <= word_sr >> 8;
                     byte_idx <= byte_idx + BI_W'(1);
                  end
               end
            end
            ST_TRL: begin
               if (accept) begin
                  tx_valid  <= 1'b0;
                  dump_done <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!done) begin
                  dump_done <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_result_dump.sv
// Bench for rv_result_dump: 2x2x2 matrices, byte scoreboard and a registered-read memory model.
module tb_rv_result_dump;

   logic        CLOCK_50 = 1'b0;
   logic        rstn = 1'b0;
   logic        done = 1'b0;
   logic [31:0] clock_count = '0;
   logic [31:0] instr_count = '0;
   logic        mem_rd_en;
   logic [31:0] mem_index;
   logic [31:0] mem_data = '0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        dump_busy;
   logic        dump_done;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [0:15];
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          byte_cyc_q[$];
   logic [31:0] rd_q[$];
   int          rd_cyc_q[$];
   int          stab_err;
   int          pulse_err;

   rv_result_dump #(.M(2), .N(2), .N2(2), .REG_WIDTH(32), .BASE(8)) dut (
      .CLOCK_50(CLOCK_50), .rstn(rstn), .done(done),
      .clock_count(clock_count), .instr_count(instr_count),
      .mem_rd_en(mem_rd_en), .mem_index(mem_index), .mem_data(mem_data),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .dump_busy(dump_busy), .dump_done(dump_done)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) if (mem_rd_en) mem_data <= mem[mem_index[3:0]];

   task automatic push_frame(input logic [31:0] cc, input logic [31:0] ic);
      exp_q.push_back(8'hA5);
      for (int i = 0; i < 4; i++) exp_q.push_back(cc[8*i +: 8]);
      for (int i = 0; i < 4; i++) exp_q.push_back(ic[8*i +: 8]);
      for (int w = 8; w < 12; w++) begin
         logic [31:0] v;
         v = mem[w];
         for (int b = 0; b < 4; b++) exp_q.push_back(v[8*b +: 8]);
      end
      exp_q.push_back(8'h5A);
   endtask

   // Clears done for two cycles (rearms from DONE) then raises it with fresh counters.
   task automatic start_frame(input logic [31:0] cc, input logic [31:0] ic);
      @(negedge CLOCK_50); done = 1'b0; tx_ready = 1'b0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      clock_count = cc; instr_count = ic; done = 1'b1;
      push_frame(cc, ic);
   endtask

   // Records accepted bytes and memory strobes until dump_done, stop_at bytes, or the bound.
   task automatic collect(input int mode, input bit inc, input bit wiggle, input int stop_at,
                          output bit timed_out);
      int cyc;
      bit pv, pr, prd;
      logic [7:0] pd;
      cyc = 0; pv = 0; pr = 0; prd = 0; pd = '0; timed_out = 0;
      got_q.delete(); byte_cyc_q.delete(); rd_q.delete(); rd_cyc_q.delete();
      stab_err = 0; pulse_err = 0;
      forever begin
         @(negedge CLOCK_50);
         cyc++;
         tx_ready = (mode == 0) ? 1'b1 : (cyc % 4 == 0);
         if (inc) clock_count = clock_count + 32'd1;
         if (wiggle && cyc == 6) done = 1'b0;
         if (wiggle && cyc == 8) begin done = 1'b1; instr_count = 32'hDEAD0000; end
         if (pv && !pr && (!tx_valid || tx_data !== pd)) stab_err++;
         if (mem_rd_en) begin
            if (prd) pulse_err++;
            rd_q.push_back(mem_index);
            rd_cyc_q.push_back(cyc);
         end
         prd = mem_rd_en;
         pv = tx_valid; pr = tx_ready; pd = tx_data;
         if (tx_valid && tx_ready) begin
            got_q.push_back(tx_data);
            byte_cyc_q.push_back(cyc);
            if (stop_at > 0 && got_q.size() == stop_at) break;
         end
         if (dump_done) break;
         if (cyc > 2000) begin timed_out = 1; break; end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; done = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      checks += 6;
      if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
      if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      if (mem_rd_en !== 1'b0) begin failures++; $display("FAIL reset_mem_rd_en got=%b exp=0", mem_rd_en); end
      if (mem_index !== 32'd0) begin failures++; $display("FAIL reset_mem_index got=%0d exp=0", mem_index); end
      if (dump_busy !== 1'b0) begin failures++; $display("FAIL reset_dump_busy got=%b exp=0", dump_busy); end
      if (dump_done !== 1'b0) begin failures++; $display("FAIL reset_dump_done got=%b exp=0", dump_done); end
      rstn = 1'b1;
      $display("test_reset: reset outputs checked");
   endtask

   task automatic test_basic();
      bit to;
      logic [7:0] e, g;
      start_frame(32'h00000064, 32'h0000002A);
      collect(0, 0, 0, 0, to);
      checks += 4;
      if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=dump_done"); end
      if (got_q.size() != 26) begin failures++; $display("FAIL basic_len got=%0d exp=26", got_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin failures++; $display("FAIL basic_byte got=%h exp=%h", g, e); end
      end
      @(negedge CLOCK_50);
      if (dump_done !== 1'b1) begin failures++; $display("FAIL basic_dump_done got=%b exp=1", dump_done); end
      if (dump_busy !== 1'b0) begin failures++; $display("FAIL basic_dump_busy got=%b exp=0", dump_busy); end
      $display("test_basic: frame of 26 bytes compared");
   endtask

   task automatic test_no_retrigger();
      int seen;
      seen = 0;
      tx_ready = 1'b1;
      repeat (30) begin
         @(negedge CLOCK_50);
         if (tx_valid) seen++;
      end
      checks += 2;
      if (seen != 0) begin failures++; $display("FAIL held_done_frame got=%0d valid cycles exp=0", seen); end
      if (dump_done !== 1'b1) begin failures++; $display("FAIL held_done_dump_done got=%b exp=1", dump_done); end
      $display("test_no_retrigger: held done produced %0d valid cycles", seen);
   endtask

   task automatic test_backpressure_and_memory();
      bit to;
      logic [7:0] e, g;
      start_frame(32'h12345678, 32'h9ABCDEF0);
      collect(1, 0, 0, 0, to);
      checks += 5;
      if (to) begin failures++; $display("FAIL bp_timeout got=timeout exp=dump_done"); end
      if (got_q.size() != 26) begin failures++; $display("FAIL bp_len got=%0d exp=26", got_q.size()); end
      if (stab_err != 0) begin failures++; $display("FAIL bp_stable got=%0d violations exp=0", stab_err); end
      if (pulse_err != 0) begin failures++; $display("FAIL rd_pulse_width got=%0d long pulses exp=0", pulse_err); end
      if (rd_q.size() != 4) begin failures++; $display("FAIL rd_count got=%0d exp=4", rd_q.size()); end
      for (int k = 0; k < 4 && k < rd_q.size(); k++) begin
         checks += 2;
         if (rd_q[k] !== 32'(8 + k)) begin failures++; $display("FAIL rd_index got=%0d exp=%0d", rd_q[k], 8 + k); end
         if (byte_cyc_q.size() > 9 + 4*k && byte_cyc_q[9 + 4*k] < rd_cyc_q[k] + 2) begin
            failures++;
            $display("FAIL rd_latency got=%0d exp>=%0d", byte_cyc_q[9 + 4*k] - rd_cyc_q[k], 2);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin failures++; $display("FAIL bp_byte got=%h exp=%h", g, e); end
      end
      $display("test_backpressure_and_memory: frame with 1-of-4 ready compared");
   endtask

   task automatic test_counter_latch();
      bit to;
      logic [7:0] e, g;
      start_frame(32'h0000FFFE, 32'h00000777);
      collect(0, 1, 1, 0, to);
      checks += 2;
      if (to) begin failures++; $display("FAIL latch_timeout got=timeout exp=dump_done"); end
      if (got_q.size() != 26) begin failures++; $display("FAIL latch_len got=%0d exp=26", got_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin failures++; $display("FAIL latch_byte got=%h exp=%h", g, e); end
      end
      $display("test_counter_latch: counters held at trigger value");
   endtask

   task automatic test_reset_mid_frame();
      bit to;
      int extra;
      logic [7:0] e, g;
      start_frame(32'h00000011, 32'h00000022);
      collect(0, 0, 0, 12, to);
      exp_q.delete();
      @(negedge CLOCK_50);
      rstn = 1'b0; done = 1'b0; tx_ready = 1'b1;
      @(negedge CLOCK_50);
      rstn = 1'b1;
      checks += 4;
      if (to) begin failures++; $display("FAIL mid_reset_timeout got=timeout exp=12 bytes"); end
      if (tx_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_tx_valid got=%b exp=0", tx_valid); end
      if (dump_busy !== 1'b0) begin failures++; $display("FAIL mid_reset_dump_busy got=%b exp=0", dump_busy); end
      if (dump_done !== 1'b0) begin failures++; $display("FAIL mid_reset_dump_done got=%b exp=0", dump_done); end
      extra = 0;
      repeat (40) begin
         @(negedge CLOCK_50);
         if (tx_valid) extra++;
      end
      checks++;
      if (extra != 0) begin failures++; $display("FAIL mid_reset_extra got=%0d exp=0", extra); end
      start_frame(32'h00000033, 32'h00000044);
      collect(0, 0, 0, 0, to);
      checks += 2;
      if (to) begin failures++; $display("FAIL fresh_timeout got=timeout exp=dump_done"); end
      if (got_q.size() != 26) begin failures++; $display("FAIL fresh_len got=%0d exp=26", got_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin failures++; $display("FAIL fresh_byte got=%h exp=%h", g, e); end
      end
      $display("test_reset_mid_frame: abort and fresh frame compared");
   endtask

   task automatic test_rearm();
      bit to;
      logic [7:0] e, g;
      start_frame(32'hCAFEF00D, 32'h01020304);
      collect(0, 0, 0, 0, to);
      checks += 2;
      if (to) begin failures++; $display("FAIL rearm_timeout got=timeout exp=dump_done"); end
      if (got_q.size() != 26) begin failures++; $display("FAIL rearm_len got=%0d exp=26", got_q.size()); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         checks++;
         if (g !== e) begin failures++; $display("FAIL rearm_byte got=%h exp=%h", g, e); end
      end
      $display("test_rearm: second frame with new counters compared");
   endtask

   initial begin
      mem[0] = '0; mem[1] = '0; mem[2] = '0; mem[3] = '0;
      mem[4] = '0; mem[5] = '0; mem[6] = '0; mem[7] = '0;
      mem[8]  = 32'h11223344;
      mem[9]  = 32'hAABBCCDD;
      mem[10] = 32'h00000001;
      mem[11] = 32'hFFFFFFFF;
      mem[12] = '0; mem[13] = '0; mem[14] = '0; mem[15] = '0;
      test_reset();
      test_basic();
      test_no_retrigger();
      test_backpressure_and_memory();
      test_counter_latch();
      test_reset_mid_frame();
      test_rearm();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
